// File: rtl/imem_lat.sv
// Read-only instruction memory with a fixed, parameterised access latency.
// One access in flight at a time; result is presented for exactly one cycle.
`timescale 1ns/1ps
module imem_lat #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned LATENCY   = 3,
    parameter string       INIT_FILE = ""
) (
    input  logic             CLK,
    input  logic             ResetN,
    input  logic             Req,
    input  logic [31:0]      A,
    input  logic             Flush,
    output logic             Ready,
    output logic [WIDTH-1:0] RD,
    output logic             Err,
    output logic             Busy
);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic [AW-1:0]    word_idx;
    logic             addr_fault;

    logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

    assign word_idx   = addr_q[AW+1:2];
    // Misaligned, or any address bit above the array's word range is set.
    assign addr_fault = (addr_q[1:0] != 2'b00) || ((addr_q >> (AW + 2)) != 32'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        ready_d = 1'b0;
        rd_d    = '0;
        err_d   = 1'b0;
        busy_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    addr_d  = A;
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_DONE;
                    ready_d = 1'b1;
                    err_d   = addr_fault;
                    rd_d    = addr_fault ? '0 : mem[word_idx];
                end
            end
            S_DONE: begin
                // Accepting here gives back-to-back accesses with no idle cycle.
                if (Req) begin
                    addr_d  = A;
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (Flush) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            ready_d = 1'b0;
            rd_d    = '0;
            err_d   = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            ready_q <= 1'b0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ready_q <= ready_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign Ready = ready_q;
    assign RD    = rd_q;
    assign Err   = err_q;
    assign Busy  = busy_q;
endmodule

// File: tb/tb_imem_lat.sv
// Bench for imem_lat: a LATENCY=3 and a LATENCY=1 instance checked every cycle
// against a due-cycle scoreboard, plus directed checks with literal expectations.
`timescale 1ns/1ps
module tb_imem_lat;
    localparam int D = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, flush0 = 1'b0, req1 = 1'b0, flush1 = 1'b0;
    logic [31:0] a0 = 32'd0, a1 = 32'd0;
    logic        ready0, err0, busy0, ready1, err1, busy1;
    logic [31:0] rd0, rd1;

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [D];

    // Scoreboard: an accepted access at cycle k is due at cycle k+latency.
    int          cyc = 0;
    bit          pend [2] = '{1'b0, 1'b0};
    int          due [2] = '{0, 0};
    logic [31:0] m_addr [2] = '{32'd0, 32'd0};
    int          lat [2] = '{3, 1};
    logic        exp_ready [2] = '{1'b0, 1'b0};
    logic        exp_err [2] = '{1'b0, 1'b0};
    logic        exp_busy [2] = '{1'b0, 1'b0};
    logic [31:0] exp_rd [2] = '{32'd0, 32'd0};

    imem_lat #(.WIDTH(32), .DEPTH(D), .LATENCY(3), .INIT_FILE("")) dut0 (
        .CLK(clk), .ResetN(rst_n), .Req(req0), .A(a0), .Flush(flush0),
        .Ready(ready0), .RD(rd0), .Err(err0), .Busy(busy0));

    imem_lat #(.WIDTH(32), .DEPTH(D), .LATENCY(1), .INIT_FILE("")) dut1 (
        .CLK(clk), .ResetN(rst_n), .Req(req1), .A(a1), .Flush(flush1),
        .Ready(ready1), .RD(rd1), .Err(err1), .Busy(busy1));

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endfunction

    function automatic void model_step(int d, logic req, logic [31:0] a, logic flush);
        exp_ready[d] = 1'b0;
        exp_rd[d]    = 32'd0;
        exp_err[d]   = 1'b0;
        if (flush) begin
            pend[d] = 1'b0;
        end else if (pend[d] && cyc == due[d]) begin
            exp_ready[d] = 1'b1;
            exp_err[d]   = (m_addr[d][1:0] != 2'b00) || (m_addr[d] >= 32'(4 * D));
            exp_rd[d]    = exp_err[d] ? 32'd0 : ref_mem[m_addr[d] / 4];
            pend[d]      = 1'b0;
        end else if (!pend[d] && req) begin
            pend[d]   = 1'b1;
            due[d]    = cyc + lat[d];
            m_addr[d] = a;
        end
        exp_busy[d] = pend[d] || exp_ready[d];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                pend[d] = 1'b0;
                exp_ready[d] = 1'b0;
                exp_rd[d] = 32'd0;
                exp_err[d] = 1'b0;
                exp_busy[d] = 1'b0;
            end
        end else begin
            model_step(0, req0, a0, flush0);
            model_step(1, req1, a1, flush1);
            cyc++;
        end
    end

    task automatic cmp(int d, logic r, logic [31:0] data, logic e, logic b);
        chk($sformatf("dut%0d ready", d), 32'(r), 32'(exp_ready[d]));
        chk($sformatf("dut%0d rd", d), data, exp_rd[d]);
        chk($sformatf("dut%0d err", d), 32'(e), 32'(exp_err[d]));
        chk($sformatf("dut%0d busy", d), 32'(b), 32'(exp_busy[d]));
        if (exp_ready[d])
            $display("xact dut%0d addr=%h rd=%h err=%0d", d, m_addr[d], data, e);
    endtask

    always @(negedge clk) begin
        cmp(0, ready0, rd0, err0, busy0);
        cmp(1, ready1, rd1, err1, busy1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_access(input logic [31:0] addr, output logic r,
                             output logic [31:0] d, output logic e);
        req0 = 1'b1;
        a0   = addr;
        step();
        req0 = 1'b0;
        repeat (3) step();
        r = ready0;
        d = rd0;
        e = err0;
        step();
    endtask

    logic        r_o, e_o;
    logic [31:0] d_o;
    int          pulses;

    initial begin
        for (int i = 0; i < D; i++) ref_mem[i] = 32'hA000_0000 | (i << 8) | i;
        ref_mem[5] = 32'h1234_5678;
        for (int i = 0; i < D; i++) begin
            dut0.mem[i] = ref_mem[i];
            dut1.mem[i] = ref_mem[i];
        end

        repeat (3) step();
        chk("reset ready", 32'(ready0), 32'd0);
        chk("reset rd", rd0, 32'd0);
        chk("reset err", 32'(err0), 32'd0);
        chk("reset busy", 32'(busy0), 32'd0);

        // First edge with reset released and Req high is edge 0.
        rst_n = 1'b1;
        req0  = 1'b1;
        a0    = 32'h14;
        step();
        req0 = 1'b0;
        a0   = 32'hFFFF_FFFC;
        chk("single busy e0", 32'(busy0), 32'd1);
        chk("single ready e0", 32'(ready0), 32'd0);
        step();
        chk("single ready e1", 32'(ready0), 32'd0);
        step();
        chk("single ready e2", 32'(ready0), 32'd0);
        step();
        chk("single ready e3", 32'(ready0), 32'd1);
        chk("single rd e3", rd0, 32'h1234_5678);
        chk("single err e3", 32'(err0), 32'd0);
        step();
        chk("single ready e4", 32'(ready0), 32'd0);
        chk("single busy e4", 32'(busy0), 32'd0);

        // Sustained Req: Ready after edges 3, 7, 11.
        req0 = 1'b1;
        a0   = 32'h0;
        step();
        a0 = 32'h4;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 4) a0 = 32'h8;
            if (i == 8) req0 = 1'b0;
            if (i == 3 || i == 7 || i == 11) begin
                chk($sformatf("b2b ready e%0d", i), 32'(ready0), 32'd1);
                chk($sformatf("b2b rd e%0d", i), rd0,
                    (i == 3) ? 32'hA000_0000 : (i == 7) ? 32'hA000_0101 : 32'hA000_0202);
            end else begin
                chk($sformatf("b2b ready e%0d", i), 32'(ready0), 32'd0);
            end
        end

        do_access(32'h100, r_o, d_o, e_o);
        chk("oor ready", 32'(r_o), 32'd1);
        chk("oor err", 32'(e_o), 32'd1);
        chk("oor rd", d_o, 32'd0);
        do_access(32'h6, r_o, d_o, e_o);
        chk("misalign err", 32'(e_o), 32'd1);
        chk("misalign rd", d_o, 32'd0);
        do_access(32'h8000_0000, r_o, d_o, e_o);
        chk("highbit err", 32'(e_o), 32'd1);
        do_access(32'hFC, r_o, d_o, e_o);
        chk("last word err", 32'(e_o), 32'd0);
        chk("last word rd", d_o, 32'hA000_3F3F);

        // Flush at edge 2 of an access.
        req0 = 1'b1;
        a0   = 32'h10;
        step();
        req0 = 1'b0;
        step();
        flush0 = 1'b1;
        step();
        flush0 = 1'b0;
        chk("flush busy", 32'(busy0), 32'd0);
        chk("flush ready", 32'(ready0), 32'd0);
        repeat (3) begin
            step();
            chk("flush no ready", 32'(ready0), 32'd0);
        end
        do_access(32'h8, r_o, d_o, e_o);
        chk("post flush ready", 32'(r_o), 32'd1);
        chk("post flush rd", d_o, 32'hA000_0202);

        // Flush and Req together: request dropped.
        req0   = 1'b1;
        flush0 = 1'b1;
        a0     = 32'h4;
        step();
        req0   = 1'b0;
        flush0 = 1'b0;
        chk("flush+req busy", 32'(busy0), 32'd0);
        repeat (4) begin
            step();
            chk("flush+req no ready", 32'(ready0), 32'd0);
        end

        // Asynchronous reset in the middle of WAIT.
        req0 = 1'b1;
        a0   = 32'h14;
        step();
        req0 = 1'b0;
        step();
        chk("pre-reset busy", 32'(busy0), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst busy", 32'(busy0), 32'd0);
        chk("async rst ready", 32'(ready0), 32'd0);
        chk("async rst rd", rd0, 32'd0);
        chk("async rst err", 32'(err0), 32'd0);
        step();
        step();
        #2;
        rst_n = 1'b1;
        repeat (5) begin
            step();
            chk("post rst no ready", 32'(ready0), 32'd0);
            chk("post rst busy", 32'(busy0), 32'd0);
        end
        do_access(32'h14, r_o, d_o, e_o);
        chk("post rst access rd", d_o, 32'h1234_5678);

        // LATENCY=1 sweep: one word every two cycles.
        pulses = 0;
        req1 = 1'b1;
        a1   = 32'h0;
        step();
        for (int j = 1; j <= D; j++) begin
            step();
            chk($sformatf("sweep ready w%0d", j - 1), 32'(ready1), 32'd1);
            chk($sformatf("sweep rd w%0d", j - 1), rd1, ref_mem[j - 1]);
            if (ready1) pulses++;
            if (j == D) req1 = 1'b0;
            a1 = 32'(4 * j);
            step();
            if (j < D) chk($sformatf("sweep gap w%0d", j - 1), 32'(ready1), 32'd0);
        end
        chk("sweep pulses", 32'(pulses), 32'd64);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule

// File: doc/imem_lat.md
IMEM_LAT -- requirements
Module: imem_lat

Interface
REQ-001 Parameter WIDTH, 32: data word width in bits, 8..64.
REQ-002 Parameter DEPTH, 64: number of words; power of two, 2..4096; AW = log2(DEPTH).
REQ-003 Parameter LATENCY, 3: wait cycles per access, 1..15.
REQ-004 Parameter INIT_FILE, "": hex image loaded into the array at elaboration; empty string -> all words zero.
REQ-005 CLK  input  1  sole clock; all state changes on rising edge.
REQ-006 ResetN  input  1  asynchronous, active-low reset.
REQ-007 Req  input  1  access request; sampled only in IDLE or DONE.
REQ-008 A  input  32  byte address; word index = A[AW+1:2].
REQ-009 Flush  input  1  synchronous cancel of any in-flight access.
REQ-010 Ready  output  1  high for exactly one cycle when RD/Err are valid.
REQ-011 RD  output  WIDTH  read data; zero whenever Ready low.
REQ-012 Err  output  1  access fault flag; valid only with Ready.
REQ-013 Busy  output  1  high in WAIT and DONE.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, DONE; all outputs registered.
REQ-015 IDLE: Req=1 at edge k SHALL latch A into an internal address register, load Cnt = LATENCY-1 and enter WAIT; Req=0 stays IDLE.
REQ-016 WAIT: Cnt != 0 -> Cnt decrements; Cnt == 0 -> enter DONE.
REQ-017 Ready SHALL be high in the cycle after edge k+LATENCY for a request accepted at edge k; no other cycle.
REQ-018 DONE: RD = RAM[latched word index], Ready = 1, lasting one cycle.
REQ-019 DONE with Req=1 SHALL accept the new A and enter WAIT (back-to-back); Req=0 -> IDLE; sustained Req gives one word per LATENCY+1 cycles.
REQ-020 Changes on A after acceptance SHALL NOT affect the in-flight access.
REQ-021 Err SHALL be set in DONE when latched A[1:0] != 0 or latched A[31:AW+2] != 0; then RD = 0.
REQ-022 Flush=1 at any edge SHALL force IDLE with Ready=0, RD=0, Err=0, Busy=0; the cancelled access never produces Ready.
REQ-023 Flush and Req high at the same edge: Flush wins; the request is dropped.
REQ-024 Memory is read-only; no write port.
REQ-025 Cnt width SHALL be 4 bits; no wrap beyond LATENCY-1.

Reset
REQ-026 ResetN low SHALL immediately force IDLE, Cnt=0, address register=0, Ready=0, RD=0, Err=0, Busy=0, independent of CLK.
REQ-027 Reset asserted mid-access SHALL abort it; no Ready after release.
REQ-028 First request is accepted at the first rising edge with ResetN high and Req high.
REQ-029 Memory contents are unaffected by reset.

Verification
REQ-030 LATENCY=3, RAM[5]=32'h1234_5678, Req pulse with A=32'h14 at edge 0 -> Ready=1, RD=32'h1234_5678, Err=0 only after edge 3.
REQ-031 Req held, A=0,4,8 as each is accepted -> Ready at edges 3, 7, 11 with RAM[0], RAM[1], RAM[2].
REQ-032 DEPTH=64, A=32'h100 -> Ready with Err=1, RD=0; A=32'h6 -> Err=1, RD=0.
REQ-033 Flush at edge 2 of a LATENCY=3 access -> no Ready, Busy=0 after edge 2; next Req accepted normally.
REQ-034 ResetN low mid-WAIT between edges -> outputs zero at once; no Ready after release until a new Req.
REQ-035 LATENCY=1 sweep of all 64 addresses with sustained Req -> 64 Ready pulses every 2 cycles, data matching INIT_FILE.
